// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule constants: FK words, CK step sizes, FSM encoding and S-box table.
// Pure declarations, no logic.
package sm4_pkg;

  localparam int SM4_ROUNDS = 32;

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  localparam logic [7:0] CK_STEP_I = 8'd28;
  localparam logic [7:0] CK_STEP_J = 8'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Byte a of the S-box lives at bits [2047-8a -: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

endpackage

// File: rtl/sm4_key_expand_trans_rk.sv
// Key-schedule T' transform: four parallel S-box lookups followed by L'(B) = B ^ (B<<<13) ^ (B<<<23).
// Purely combinational.
module sbox
  import sm4_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = SBOX_TABLE[(255 - int'(din)) * 8 +: 8];

endmodule

module trans_rk (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  logic [31:0] sub;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox u_sbox (
      .din  (din[8*g +: 8]),
      .dout (sub[8*g +: 8])
    );
  end

  assign dout = sub ^ {sub[18:0], sub[31:19]} ^ {sub[8:0], sub[31:9]};

endmodule

// File: rtl/sm4_key_expand.sv
// Sequential SM4 key expansion: one master key in, rk0..rk31 out one per accepted beat through a shared T'.
// First key one cycle after the key handshake; rk_ready low freezes rk_out, rk_idx and the K window.
module sm4_key_expand
  import sm4_pkg::*;
#(
  parameter int ROUNDS = SM4_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [31:0]  rk_out,
  output logic [4:0]   rk_idx,
  output logic         rk_last,
  output logic         busy
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] k_q [4];
  logic [31:0] k_d [4];
  logic [31:0] rk_out_q, rk_out_d;
  logic [4:0]  rk_idx_q, rk_idx_d;
  logic        rk_valid_q, rk_valid_d;

  logic [7:0]  ck_b0;
  logic [31:0] ck;
  logic [31:0] tr_in, tr_out, rk_new;
  logic        adv, last_hs;

  // CK byte j = 28*i + 7*j, wrapping in 8 bits.
  always_comb begin
    ck_b0 = 8'({2'b00, cnt_q} * CK_STEP_I);
    ck    = {ck_b0,
             ck_b0 + CK_STEP_J,
             ck_b0 + 8'(2 * CK_STEP_J),
             ck_b0 + 8'(3 * CK_STEP_J)};
  end

  assign tr_in  = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck;
  assign rk_new = k_q[0] ^ tr_out;

  trans_rk u_trans_rk (
    .din  (tr_in),
    .dout (tr_out)
  );

  assign adv     = (state_q == ST_RUN) && (int'(cnt_q) < ROUNDS) && (!rk_valid_q || rk_ready);
  assign last_hs = rk_valid_q && rk_ready && (int'(rk_idx_q) == ROUNDS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rk_out_q   <= '0;
      rk_idx_q   <= '0;
      rk_valid_q <= 1'b0;
      for (int j = 0; j < 4; j++) k_q[j] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rk_out_q   <= rk_out_d;
      rk_idx_q   <= rk_idx_d;
      rk_valid_q <= rk_valid_d;
      for (int j = 0; j < 4; j++) k_q[j] <= k_d[j];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (key_valid) state_d = ST_RUN;
      ST_RUN:  if (last_hs)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    rk_out_d   = rk_out_q;
    rk_idx_d   = rk_idx_q;
    rk_valid_d = rk_valid_q;
    for (int j = 0; j < 4; j++) k_d[j] = k_q[j];

    if (state_q == ST_IDLE) begin
      if (key_valid) begin
        k_d[0] = key_in[127:96] ^ FK0;
        k_d[1] = key_in[95:64]  ^ FK1;
        k_d[2] = key_in[63:32]  ^ FK2;
        k_d[3] = key_in[31:0]   ^ FK3;
        cnt_d  = '0;
      end
    end else begin
      if (adv) begin
        k_d[0]     = k_q[1];
        k_d[1]     = k_q[2];
        k_d[2]     = k_q[3];
        k_d[3]     = rk_new;
        rk_out_d   = rk_new;
        rk_idx_d   = cnt_q[4:0];
        rk_valid_d = 1'b1;
        cnt_d      = cnt_q + 6'd1;
      end else if (rk_valid_q && rk_ready) begin
        rk_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    key_ready = (state_q == ST_IDLE);
    busy      = (state_q == ST_RUN);
    rk_valid  = rk_valid_q;
    rk_out    = rk_out_q;
    rk_idx    = rk_idx_q;
    rk_last   = rk_valid_q && (int'(rk_idx_q) == ROUNDS - 1);
  end

endmodule

// File: tb/tb_sm4_key_expand.sv
// Directed bench for sm4_key_expand: standard vector, CK probes, backpressure,
// busy-time key offers, back-to-back keys and mid-run reset, against a behavioural key-schedule model.
module tb_sm4_key_expand;

  logic         clk;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [31:0]  rk_out;
  logic [4:0]   rk_idx;
  logic         rk_last;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_rk [32];
  logic [31:0] cap    [32];

  localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;

  localparam logic [2047:0] TB_SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  sm4_key_expand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_out    (rk_out),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] x);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      logic [7:0] a;
      a = x[8*b +: 8];
      r[8*b +: 8] = TB_SBOX[2047 - 8*int'(a) -: 8];
    end
    return r;
  endfunction

  task automatic compute_ref(input logic [127:0] mk);
    logic [31:0] k [4];
    logic [31:0] ckw, b, nw;
    k[0] = mk[127:96] ^ 32'hA3B1BAC6;
    k[1] = mk[95:64]  ^ 32'h56AA3350;
    k[2] = mk[63:32]  ^ 32'h677D9197;
    k[3] = mk[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ckw[31 - 8*j -: 8] = 8'((28 * i + 7 * j) % 256);
      b  = tau(k[1] ^ k[2] ^ k[3] ^ ckw);
      nw = k[0] ^ b ^ rol(b, 13) ^ rol(b, 23);
      exp_rk[i] = nw;
      k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = nw;
    end
  endtask

  // Offers a key and returns at the falling edge after the handshake edge.
  task automatic send_key(input logic [127:0] key, input bit hold, input logic [127:0] next_key);
    int n;
    @(negedge clk);
    key_in    = key;
    key_valid = 1'b1;
    n = 0;
    while (!key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!key_ready) check("key_ready_timeout", 32'(key_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (hold) key_in = next_key;
    else key_valid = 1'b0;
    #1;
    check("start_busy", 32'(busy), 32'd1);
    check("start_krdy", 32'(key_ready), 32'd0);
    check("start_vld", 32'(rk_valid), 32'd0);
  endtask

  task automatic recv(input bit rnd, input int n, input bit chk_lat);
    int got;
    bit stalled, seen;
    logic [31:0] h_out;
    logic [4:0]  h_idx;
    got = 0; stalled = 0; seen = 0; h_out = '0; h_idx = '0;
    for (int cyc = 0; cyc < 600 && got < n; cyc++) begin
      @(negedge clk);
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (chk_lat && !seen && rk_valid) check("first_latency", 32'(cyc), 32'd0);
      if (rk_valid) seen = 1;
      if (stalled) begin
        check("stall_vld", 32'(rk_valid), 32'd1);
        check("stall_out", rk_out, h_out);
        check("stall_idx", 32'(rk_idx), 32'(h_idx));
      end
      if (dut.cnt_q == 6'd31) check("ck31", dut.ck, 32'h646B7279);
      if (rk_valid) begin
        check("run_krdy", 32'(key_ready), 32'd0);
        if (rk_ready) begin
          check("rk", rk_out, exp_rk[got]);
          check("rk_idx", 32'(rk_idx), 32'(got));
          check("rk_last", 32'(rk_last), 32'(got == 31));
          cap[got] = rk_out;
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          h_out = rk_out;
          h_idx = rk_idx;
        end
      end else begin
        stalled = 0;
      end
    end
    check("beats", 32'(got), 32'(n));
  endtask

  task automatic check_idle_after();
    @(negedge clk);
    #1;
    check("end_krdy", 32'(key_ready), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_vld", 32'(rk_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_krdy"}, 32'(key_ready), 32'd1);
    check({tag, "_vld"},  32'(rk_valid), 32'd0);
    check({tag, "_out"},  rk_out, 32'd0);
    check({tag, "_idx"},  32'(rk_idx), 32'd0);
    check({tag, "_last"}, 32'(rk_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [127:0] ka, kb;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rk_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Standard vector, consumer always ready.
    compute_ref(STD_KEY);
    send_key(STD_KEY, 1'b0, '0);
    recv(1'b0, 32, 1'b1);
    check("std_rk0",  cap[0],  32'hF12186F9);
    check("std_rk1",  cap[1],  32'h41662B61);
    check("std_rk2",  cap[2],  32'h5A6AB19A);
    check("std_rk3",  cap[3],  32'h7BA92077);
    check("std_rk31", cap[31], 32'h9124A012);
    check_idle_after();

    // CK probes with the first key stalled, then random backpressure.
    ka = {$urandom, $urandom, $urandom, $urandom};
    compute_ref(ka);
    rk_ready = 1'b0;
    send_key(ka, 1'b0, '0);
    check("ck0", dut.ck, 32'h00070E15);
    @(negedge clk);
    #1;
    check("ck1", dut.ck, 32'h1C232A31);
    check("stall0_vld", 32'(rk_valid), 32'd1);
    check("stall0_idx", 32'(rk_idx), 32'd0);
    check("stall0_out", rk_out, exp_rk[0]);
    recv(1'b1, 32, 1'b0);
    check_idle_after();

    // Second key offered throughout the first stream, then accepted immediately after it.
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    compute_ref(ka);
    rk_ready = 1'b1;
    send_key(ka, 1'b1, kb);
    recv(1'b0, 32, 1'b1);
    compute_ref(kb);
    @(negedge clk);
    #1;
    check("b2b_krdy", 32'(key_ready), 32'd1);
    check("b2b_vld", 32'(rk_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    #1;
    check("b2b_busy", 32'(busy), 32'd1);
    recv(1'b0, 32, 1'b1);
    check_idle_after();

    // Reset asserted after ten round keys, then a fresh key.
    ka = {$urandom, $urandom, $urandom, $urandom};
    compute_ref(ka);
    send_key(ka, 1'b0, '0);
    recv(1'b0, 10, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    kb = {$urandom, $urandom, $urandom, $urandom};
    compute_ref(kb);
    send_key(kb, 1'b0, '0);
    recv(1'b0, 32, 1'b1);
    check_idle_after();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
